// File: rtl/clock_ctrl.sv
// Front-panel controller for the h/m/s clock core: button edge detect, run/select FSM,
// field clear pulses, latched alarm comparator and a blink strobe for the selected field.
module clock_ctrl #(
   parameter int P_SEC_BIT   = 6,
   parameter int P_HOUR_BIT  = 5,
   parameter int P_BLINK_DIV = 25_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  btn_start,
   input  logic                  btn_mode,
   input  logic                  btn_clr,
   input  logic                  alarm_en,
   input  logic [P_SEC_BIT-1:0]  i_alarm_min,
   input  logic [P_HOUR_BIT-1:0] i_alarm_hour,
   input  logic [P_SEC_BIT-1:0]  sec,
   input  logic [P_SEC_BIT-1:0]  min,
   input  logic [P_HOUR_BIT-1:0] hour,
   output logic                  en,
   output logic                  reset_s,
   output logic                  reset_m,
   output logic                  reset_h,
   output logic                  reset_all,
   output logic [1:0]            sel,
   output logic                  blink,
   output logic                  alarm
);

   localparam int CW = (P_BLINK_DIV > 2) ? $clog2(P_BLINK_DIV) : 1;

   typedef enum logic [2:0] {STOP, RUN, SEL_S, SEL_M, SEL_H} state_t;

   state_t                 state, state_n;
   logic                   start_q, mode_q, clr_q, armed;
   logic                   start_p, mode_p, clr_p;
   logic [1:0]             sel_n;
   logic [P_SEC_BIT-1:0]   sec_q;
   logic [CW-1:0]          blink_cnt;
   logic                   alarm_set, alarm_clr;

   // armed masks the first edge after reset so a button already held is only resampled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q <= 1'b0;
         mode_q  <= 1'b0;
         clr_q   <= 1'b0;
         armed   <= 1'b0;
         sec_q   <= '0;
      end else begin
         start_q <= btn_start;
         mode_q  <= btn_mode;
         clr_q   <= btn_clr;
         armed   <= 1'b1;
         sec_q   <= sec;
      end
   end

   always_comb begin
      start_p = armed & btn_start & ~start_q;
      mode_p  = armed & btn_mode & ~mode_q & ~start_p;
      clr_p   = armed & btn_clr & ~clr_q & ~start_p & ~mode_p;
   end

   always_comb begin
      state_n = state;
      if (start_p) begin
         state_n = (state == RUN) ? STOP : RUN;
      end else if (mode_p) begin
         case (state)
            STOP:    state_n = SEL_S;
            SEL_S:   state_n = SEL_M;
            SEL_M:   state_n = SEL_H;
            SEL_H:   state_n = STOP;
            default: state_n = state;
         endcase
      end
      case (state_n)
         SEL_S:   sel_n = 2'd1;
         SEL_M:   sel_n = 2'd2;
         SEL_H:   sel_n = 2'd3;
         default: sel_n = 2'd0;
      endcase
   end

   // clr_p is only set when no start/mode press, so the state holds during a clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= STOP;
         en        <= 1'b0;
         sel       <= 2'd0;
         reset_s   <= 1'b0;
         reset_m   <= 1'b0;
         reset_h   <= 1'b0;
         reset_all <= 1'b0;
      end else begin
         state     <= state_n;
         en        <= (state_n == RUN);
         sel       <= sel_n;
         reset_all <= clr_p & (state == STOP);
         reset_s   <= clr_p & (state == SEL_S);
         reset_m   <= clr_p & (state == SEL_M);
         reset_h   <= clr_p & (state == SEL_H);
      end
   end

   always_comb begin
      alarm_set = (state == RUN) & alarm_en & (hour == i_alarm_hour) &
                  (min == i_alarm_min) & (sec == '0) & (sec_q != '0);
      alarm_clr = ~alarm_en | clr_p | start_p;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alarm <= 1'b0;
      end else if (alarm_clr) begin
         alarm <= 1'b0;
      end else if (alarm_set) begin
         alarm <= 1'b1;
      end
   end

   // uses the next sel so the restart lands on the same edge as the field change
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if ((sel_n == 2'd0) || (sel_n != sel)) begin
         blink_cnt <= '0;
         blink     <= 1'b0;
      end else if (blink_cnt == CW'(P_BLINK_DIV - 1)) begin
         blink_cnt <= '0;
         blink     <= ~blink;
      end else begin
         blink_cnt <= blink_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl: a run/field-level reference model pushes the expected
// output vector per edge; a monitor pops and compares one edge later.
module tb_clock_ctrl;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_start = 1'b0, btn_mode = 1'b0, btn_clr = 1'b0, alarm_en = 1'b0;
   logic [5:0] i_alarm_min = '0, sec = '0, min = '0;
   logic [4:0] i_alarm_hour = '0, hour = '0;
   logic       en, reset_s, reset_m, reset_h, reset_all, blink, alarm;
   logic [1:0] sel;

   int errors = 0;
   int checks = 0;
   int cyc_no = 0;

   logic [8:0] exp_q[$];
   logic [8:0] dut_vec;

   bit m_run, m_alarm, m_armed, p_s, p_m, p_c;
   int m_field, m_sec_prev, m_age;

   clock_ctrl #(.P_SEC_BIT(6), .P_HOUR_BIT(5), .P_BLINK_DIV(DIV)) dut (
      .clk(clk), .reset(reset), .btn_start(btn_start), .btn_mode(btn_mode),
      .btn_clr(btn_clr), .alarm_en(alarm_en), .i_alarm_min(i_alarm_min),
      .i_alarm_hour(i_alarm_hour), .sec(sec), .min(min), .hour(hour),
      .en(en), .reset_s(reset_s), .reset_m(reset_m), .reset_h(reset_h),
      .reset_all(reset_all), .sel(sel), .blink(blink), .alarm(alarm)
   );

   always #5 clk = ~clk;

   assign dut_vec = {en, sel, reset_s, reset_m, reset_h, reset_all, blink, alarm};

   always @(posedge clk) begin
      #1;
      cyc_no++;
      if (exp_q.size() != 0) begin
         logic [8:0] e;
         e = exp_q.pop_front();
         checks++;
         if (dut_vec !== e) begin
            errors++;
            $display("FAIL outputs cyc %0d: got {en,sel,rs,rm,rh,ra,blink,alarm}=%b required %b",
                     cyc_no, dut_vec, e);
         end
      end
   end

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b required %b", name, act, req);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_alarm = 0; m_armed = 0; p_s = 0; p_m = 0; p_c = 0;
      m_field = 0; m_sec_prev = 0; m_age = 0;
   endtask

   // behavioural model: "running" flag plus selected field number, alarm flag, blink age
   task automatic step();
      bit ps, pm, pc, rs, rm, rh, ra, was_run, set_a, clr_a, blink_e;
      int old_field;
      ps = m_armed && btn_start && !p_s;
      pm = m_armed && btn_mode && !p_m && !ps;
      pc = m_armed && btn_clr && !p_c && !ps && !pm;
      was_run = m_run;
      old_field = m_field;
      rs = 0; rm = 0; rh = 0; ra = 0;
      if (ps) begin
         m_run = !m_run;
         m_field = 0;
      end else if (pm) begin
         if (!m_run) m_field = (m_field + 1) % 4;
      end else if (pc && !m_run) begin
         case (m_field)
            0: ra = 1;
            1: rs = 1;
            2: rm = 1;
            default: rh = 1;
         endcase
      end
      set_a = was_run && alarm_en && (hour == i_alarm_hour) && (min == i_alarm_min) &&
              (sec == 0) && (m_sec_prev != 0);
      clr_a = !alarm_en || pc || ps;
      if (clr_a) m_alarm = 0;
      else if (set_a) m_alarm = 1;
      if (m_field == 0 || m_field != old_field) m_age = 0;
      else m_age++;
      blink_e = (m_field != 0) && (((m_age / DIV) % 2) == 1);
      m_sec_prev = int'(sec);
      p_s = btn_start; p_m = btn_mode; p_c = btn_clr;
      m_armed = 1;
      exp_q.push_back({m_run, 2'(m_field), rs, rm, rh, ra, blink_e, m_alarm});
   endtask

   task automatic cyc(input logic s, input logic m, input logic c);
      btn_start = s; btn_mode = m; btn_clr = c;
      step();
      @(posedge clk); #2;
   endtask

   task automatic set_time(input int h, input int mi, input int s);
      hour = 5'(h); min = 6'(mi); sec = 6'(s);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      check("reset en/sel/clears", {en, sel, reset_s, reset_m, reset_h, reset_all}, 9'd0);
      check("reset blink", {8'd0, blink}, 9'd0);
      check("reset alarm", {8'd0, alarm}, 9'd0);
      @(posedge clk); #2;
      @(posedge clk); #2;
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      cyc(0, 0, 0); cyc(0, 0, 0);
      repeat (10) cyc(1, 0, 0);
      cyc(0, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);
      repeat (4) begin cyc(0, 1, 0); cyc(0, 0, 0); end
      cyc(0, 1, 0); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0);
      cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 0);
      cyc(0, 1, 0); cyc(0, 0, 0);
      cyc(0, 0, 1); cyc(0, 0, 0);
      cyc(1, 0, 0); cyc(0, 0, 0);
      cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 1, 0); cyc(0, 0, 0);
      cyc(1, 0, 0); cyc(0, 0, 0);
      cyc(0, 0, 1); cyc(0, 0, 0);
      cyc(1, 1, 1); cyc(0, 0, 0); cyc(0, 0, 0);

      alarm_en = 1'b1; i_alarm_hour = 5'd7; i_alarm_min = 6'd30;
      set_time(7, 29, 59); repeat (3) cyc(0, 0, 0);
      set_time(7, 30, 0);  repeat (5) cyc(0, 0, 0);
      cyc(0, 0, 1); cyc(0, 0, 0); cyc(0, 0, 0);
      set_time(7, 29, 59); repeat (2) cyc(0, 0, 0);
      set_time(7, 30, 0);  repeat (3) cyc(0, 0, 0);
      cyc(1, 0, 0); cyc(0, 0, 0);
      set_time(7, 29, 59); cyc(0, 0, 0);
      set_time(7, 30, 0);  repeat (3) cyc(0, 0, 0);

      cyc(0, 1, 0);
      repeat (6) cyc(0, 0, 0);
      btn_start = 1'b1;
      do_reset();
      cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         alarm_en = ($urandom_range(0, 15) != 0);
         hour = ($urandom_range(0, 3) != 0) ? 5'd7 : 5'($urandom_range(0, 23));
         min  = ($urandom_range(0, 3) != 0) ? 6'd30 : 6'($urandom_range(0, 59));
         sec  = ($urandom_range(0, 1) != 0) ? 6'd0 : 6'($urandom_range(0, 59));
         cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0));
      end
      cyc(0, 0, 0);
      @(posedge clk); #2;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Front-panel controller for the hours/minutes/seconds clock datapath. Turns three debounced push-button levels into the datapath's count enable and its per-field and global clear pulses. Adds an alarm comparator against the running time and a blink strobe for the display. Sits between the button debouncers and the clock core; it owns `en`, `reset_s`, `reset_m`, `reset_h` and `reset_all` of the core and reads back `sec`, `min` and `hour`.

## Interface
- `P_SEC_BIT`, 6, width of seconds and minutes buses
- `P_HOUR_BIT`, 5, width of hour bus
- `P_BLINK_DIV`, 25_000_000, clk cycles per blink half-period (≥2)
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- `btn_start`  in  1  debounced level, run/stop toggle
- `btn_mode`  in  1  debounced level, field-select step
- `btn_clr`  in  1  debounced level, clear / alarm acknowledge
- `alarm_en`  in  1  level, alarm armed
- `i_alarm_min`  in  P_SEC_BIT  alarm minute (0–59)
- `i_alarm_hour`  in  P_HOUR_BIT  alarm hour (0–23)
- `sec`, `min`  in  P_SEC_BIT  current time from clock core
- `hour`  in  P_HOUR_BIT  current time from clock core
- `en`  out  1  count enable to clock core
- `reset_s`, `reset_m`, `reset_h`, `reset_all`  out  1 each  one-cycle clear pulses to clock core
- `sel`  out  2  selected field: 0 none, 1 sec, 2 min, 3 hour
- `blink`  out  1  square wave for flashing the selected field
- `alarm`  out  1  alarm ringing, latched

## Operation
- Rising-edge detect per button. One registered copy of each button is kept. A press is detected at the edge where the button is 1 and its registered copy is 0. Holding a button gives exactly one press.
- FSM states: STOP, RUN, SEL_S, SEL_M, SEL_H. Reset state is STOP.
- STOP: en=0, sel=0.
  - start → RUN.
  - mode → SEL_S.
  - clr → one-cycle `reset_all`.
- RUN: en=1, sel=0.
  - start → STOP.
  - mode is ignored.
  - clr acknowledges the alarm only; it generates no clear pulse.
- SEL_S / SEL_M / SEL_H: en=0, sel=1/2/3.
  - mode advances SEL_S→SEL_M→SEL_H→STOP.
  - clr → one-cycle `reset_s` / `reset_m` / `reset_h` respectively.
  - start → RUN; this leaves select mode directly.
- Simultaneous presses in one cycle: priority start > mode > clr. Lower-priority presses in that cycle are discarded.
- At most one clear output is high in any cycle. Clear outputs are never high while en=1.
- Alarm set condition, evaluated every cycle: state=RUN, alarm_en=1, hour==i_alarm_hour, min==i_alarm_min, sec==0, and sec was nonzero last cycle. The last term is a registered copy of sec, so the alarm fires once per match.
- Alarm clear, each of which wins over set in the same cycle:
  - alarm_en=0
  - clr press in any state
  - start press
- Blink: a counter counts 0..P_BLINK_DIV-1. `blink` toggles on wrap. The counter and `blink` are held at 0 whenever sel=0. They restart from 0, blink=0, on every sel change.

## Timing
- Every output is registered.
- Reset values: en=0, all clear pulses 0, sel=0, blink=0, alarm=0, edge registers 0, alarm sec-history 0, blink counter 0.
- Latency: a button first sampled high at edge k updates the state and outputs at edge k. They are visible in cycle k+1. Clear pulses are high for exactly the cycle after edge k.
- `en` changes on the same edge as the state. There are no glitches or idle cycles between RUN and STOP.
- Alarm asserts on the edge after the clock core presents sec=0 at the matching minute. That is a one-cycle compare latency.
- Reset asserted mid-operation forces all registers to reset values immediately (asynchronous). Deassertion is taken on the next clk edge. A button already high at deassertion is not a press, because the edge registers resample it first.
- `reset_all` and the field clears depend only on the state and button presses. They do not depend on the time inputs.

## Test plan
- Reset, then hold btn_start high for 10 cycles → en rises one cycle after the first sample and stays 1. There is no second toggle. Release and press again → en=0.
- From STOP, press mode 4 times → sel goes 1,2,3,0 and en stays 0. In SEL_M, press clr → `reset_m`=1 for exactly 1 cycle, and the other clears stay 0.
- In RUN, press clr → no clear pulse. In STOP, press clr → single `reset_all` pulse.
- Press btn_start, btn_mode and btn_clr in the same cycle from STOP → RUN, sel=0, no clear pulse.
- Set alarm 07:30 with alarm_en=1. Drive time 07:29:59 → 07:30:00 in RUN → alarm=1 one cycle later. Hold 07:30:00 for several cycles → alarm stays latched with no re-trigger. Press clr → alarm=0. In STOP with the same time → no alarm.
- Set P_BLINK_DIV=4 and enter SEL_S → blink 0 for 4 cycles, then 1 for 4 cycles, repeating. Assert reset mid-blink → blink, sel and en are 0 immediately.
